ttl_dff_bank: RTL and testbench
===============================

// Module: ttl_dff_bank
// PURPOSE
//  Parametrised bank of 7474-style D flip-flops. CHANNELS independent channels, each WIDTH bits wide.
//  Each channel has its own TTL clock pin, active-low clear and active-low preset.
//  The whole bank runs on one system clock: TTL clocks are sampled, then rising-edge detected into enables.
//  Drop-in successor for discrete flop models in the arcade board netlists (latches, gating, sprite regs).
// PARAMETERS
//  CHANNELS     2   number of independent flop channels (>=1)
//  WIDTH        1   bits per channel sharing one tclk/clr_n/pre_n (>=1)
//  SYNC_STAGES  0   synchroniser flops on each tclk bit (0 = tclk already clk-synchronous, max 3)
//  RESET_VALUE  0   1-bit value loaded into every q bit on reset
// PORTS
//  clk     in   1                system clock; all state changes on its rising edge
//  reset   in   1                asynchronous, active-high reset
//  tclk    in   CHANNELS         per-channel TTL clock pin (level, sampled)
//  clr_n   in   CHANNELS         per-channel clear, active low, level-sensitive, clk-synchronous
//  pre_n   in   CHANNELS         per-channel preset, active low, level-sensitive, clk-synchronous
//  d       in   CHANNELS*WIDTH   data; channel c occupies d[c*WIDTH +: WIDTH]
//  q       out  CHANNELS*WIDTH   registered flop outputs, same packing as d
//  q_n     out  CHANNELS*WIDTH   complementary outputs (see CONFIGURATION)
//  rise    out  CHANNELS         registered strobe: tclk rising edge accepted (capture done) this cycle
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - All q bits = RESET_VALUE; q_n = ~q; rise = 0.
//   - Synchroniser stages and edge-history regs = 1, so tclk held high through reset causes no capture.
//  Edge detect:
//   - ts = tclk after SYNC_STAGES flops (combinational when 0); tp = ts delayed one clk.
//   - edge = ts & ~tp.
//   - tp updates every clk regardless of clr/pre.
//  Per channel, per clk, priority order:
//   1. clr_n==0          -> q = all 0.
//   2. else pre_n==0     -> q = all 1.
//   3. else edge         -> q = d sampled this cycle; rise = 1 next cycle.
//   4. else              -> q holds; rise = 0.
//  Latency:
//   - clr/pre: q changes one clk after the level is sampled.
//   - tclk rise: q updates SYNC_STAGES+1 clks after tclk first sampled high.
//  Boundary conditions:
//   - An edge while clr or pre is active is consumed and lost; no capture after release.
//   - Release of clr/pre: q holds the cleared/preset value until the next accepted edge.
//   - Release coinciding with an edge (clr_n=pre_n=1 that cycle) captures d.
//   - tclk high for many clks gives exactly one capture; low-high-low each clk gives one capture per rise.
//   - Channels are fully independent; simultaneous events on different channels never interact.
//   - Reset mid-stream discards any pending edge in the synchroniser.
// CONFIGURATION
//  Macro TTL_DFF_BOTH_LOW_EN.
//  Defined:
//   - A channel with clr_n==0 and pre_n==0 drives q = all 1 and q_n = all 1 (real 74LS74 illegal state).
//   - On release of both, q_n returns to ~q; q then holds the value set by whichever input released last.
//   - Simultaneous release leaves q = all 1.
//  Undefined:
//   - clr has priority; q = all 0 and q_n = ~q always.
//   - q_n is purely combinational ~q.
// STRUCTURE
//  Package ttl_pkg:
//   - localparam MAX_SYNC_STAGES = 3.
//   - typedef of the per-channel priority action {HOLD, CLEAR, PRESET, CAPTURE}, shared with later 74xx bank models.
//  Sub-module ttl_edge_det:
//   - One instance per channel: SYNC_STAGES synchroniser plus tp register.
//   - Outputs the edge pulse; parameter SYNC_STAGES; reset-to-1 history.
//  Top: generate loop over CHANNELS; action decode; q/q_n/rise registers.
// TESTING
//  1. CHANNELS=2 WIDTH=4 SYNC_STAGES=0: reset with tclk=1, release, hold 5 clks
//     -> q=0x00, rise never 1.
//  2. ch0 d=0xA, tclk 0->1 -> q[3:0]=0xA one clk later, rise[0]=1 for one clk; ch1 q unchanged.
//  3. ch1: clr_n=0 for 3 clks with two tclk rises, d=0xF -> q[7:4]=0x0 throughout.
//     Release with no edge -> stays 0x0; next rise captures 0xF.
//  4. clr_n=pre_n=0 on ch0 -> q[3:0]=0x0 and q_n=0xF.
//     With TTL_DFF_BOTH_LOW_EN -> q=0xF, q_n=0xF; release pre_n first -> q=0x0.
//  5. SYNC_STAGES=2: tclk rise at cycle n -> q updates at n+3; tclk held high 10 clks -> exactly one rise pulse.
//  6. Assert reset mid-synchroniser (edge in flight, SYNC_STAGES=2)
//     -> q=RESET_VALUE, no capture after release even though tclk remains high.

Source files
------------

// File: rtl/ttl_dff_bank_pkg.sv
// ----------------------------------------------------------------------------
// Package : ttl_pkg
// Purpose : Shared definitions for the 74xx-style flop bank models.
//           Holds the synchroniser depth limit, the per-channel priority
//           action type and the helper that turns the clear/preset/edge
//           inputs of one channel into that action.
// Macro   : TTL_DFF_BOTH_LOW_EN
//           When defined, clear and preset low together selects PRESET
//           (the 74LS74 "both outputs high" state). The caller is expected
//           to force q_n high while that condition is registered.
//           When undefined, clear always wins.
// ----------------------------------------------------------------------------
package ttl_pkg;

    // Deepest synchroniser chain any bank model will build on a TTL clock pin.
    localparam int MAX_SYNC_STAGES = 3;

    // What a single channel does on the next system clock edge.
    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        CLEAR   = 2'd1,
        PRESET  = 2'd2,
        CAPTURE = 2'd3
    } ttl_action_e;

    // Priority decode for one channel: clear, then preset, then a detected
    // rising edge of the TTL clock. An edge arriving while clear or preset is
    // active is simply dropped, which matches the discrete part.
    function automatic ttl_action_e decode_action(
        input logic clrN,
        input logic preN,
        input logic edgeSeen
    );
        ttl_action_e act;
        act = HOLD;
        if (!clrN) begin
            act = CLEAR;
        end else if (!preN) begin
            act = PRESET;
        end else if (edgeSeen) begin
            act = CAPTURE;
        end
`ifdef TTL_DFF_BOTH_LOW_EN
        // Both inputs low drives q high like the real chip.
        if (!clrN && !preN) begin
            act = PRESET;
        end
`endif
        return act;
    endfunction

endpackage

// File: rtl/ttl_dff_bank_if.sv
// ----------------------------------------------------------------------------
// Interface : ttl_dff_bank_if
// Purpose   : Bundles the per-channel TTL pins of a ttl_dff_bank.
// Signals   :
//   tclk  [CHANNELS]        per-channel TTL clock pin level
//   clr_n [CHANNELS]        per-channel clear, active low
//   pre_n [CHANNELS]        per-channel preset, active low
//   d     [CHANNELS*WIDTH]  data, channel c at d[c*WIDTH +: WIDTH]
//   q     [CHANNELS*WIDTH]  registered flop outputs, same packing as d
//   q_n   [CHANNELS*WIDTH]  complementary outputs
//   rise  [CHANNELS]        strobe, high the cycle a capture becomes visible
// Modports :
//   master  drives the pins (board netlist / testbench side)
//   slave   the flop bank itself
// ----------------------------------------------------------------------------
interface ttl_dff_bank_if #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 1
);

    logic [CHANNELS-1:0]       tclk;
    logic [CHANNELS-1:0]       clr_n;
    logic [CHANNELS-1:0]       pre_n;
    logic [CHANNELS*WIDTH-1:0] d;
    logic [CHANNELS*WIDTH-1:0] q;
    logic [CHANNELS*WIDTH-1:0] q_n;
    logic [CHANNELS-1:0]       rise;

    modport master (
        output tclk,
        output clr_n,
        output pre_n,
        output d,
        input  q,
        input  q_n,
        input  rise
    );

    modport slave (
        input  tclk,
        input  clr_n,
        input  pre_n,
        input  d,
        output q,
        output q_n,
        output rise
    );

endinterface

// File: rtl/ttl_dff_bank_edge_det.sv
// ----------------------------------------------------------------------------
// Module  : ttl_edge_det
// Purpose : Rising-edge detector for one TTL clock pin sampled by the system
//           clock. An optional synchroniser chain (SYNC_STAGES flops, clamped
//           to MAX_SYNC_STAGES) feeds a one-cycle history register; the edge
//           pulse is the synchronised level high while the history is low.
//           Every stage and the history reset to 1 so a pin held high across
//           reset never looks like a fresh edge, and anything in flight in the
//           chain when reset hits is discarded.
// Ports   :
//   clk     in  system clock
//   rst     in  asynchronous active-high reset
//   i_tclk  in  raw TTL clock pin level
//   o_edge  out combinational edge pulse, one system clock wide
// ----------------------------------------------------------------------------
module ttl_edge_det
    import ttl_pkg::*;
#(
    parameter int SYNC_STAGES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tclk,
    output logic o_edge
);

    localparam int STAGES = (SYNC_STAGES > MAX_SYNC_STAGES) ? MAX_SYNC_STAGES : SYNC_STAGES;

    logic w_ts;
    logic r_tp;

    generate
        if (STAGES == 0) begin : g_nosync
            // Pin is already synchronous to clk; use it directly.
            assign w_ts = i_tclk;
        end else begin : g_sync
            logic [STAGES:1] r_sync;

            // Synchroniser chain, stage 1 samples the pin, last stage is used.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync <= '1;
                end else begin
                    r_sync[1] <= i_tclk;
                    for (int k = 2; k <= STAGES; k++) begin
                        r_sync[k] <= r_sync[k-1];
                    end
                end
            end

            assign w_ts = r_sync[STAGES];
        end
    endgenerate

    // History of the synchronised level; updates every clock regardless of
    // what the channel decides to do with the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tp <= 1'b1;
        end else begin
            r_tp <= w_ts;
        end
    end

    assign o_edge = w_ts & ~r_tp;

endmodule

// File: rtl/ttl_dff_bank.sv
// ----------------------------------------------------------------------------
// Module  : ttl_dff_bank
// Purpose : Bank of CHANNELS independent 7474-style D flip-flops, each WIDTH
//           bits wide, all running on one system clock. Each channel's TTL
//           clock pin is edge-detected into a capture enable; clear and
//           preset are level-sensitive and synchronous to clk.
// Params  :
//   CHANNELS     number of channels (>=1)
//   WIDTH        bits per channel (>=1)
//   SYNC_STAGES  synchroniser flops on each tclk (0..3)
//   RESET_VALUE  value of every q bit after reset
// Ports   :
//   clk   in     system clock
//   rst   in     asynchronous active-high reset, released synchronously
//   bus   slave  ttl_dff_bank_if: tclk/clr_n/pre_n/d in, q/q_n/rise out
// Macro   : TTL_DFF_BOTH_LOW_EN
//   Defined   - clear and preset low together give q = 1 and q_n = 1.
//   Undefined - clear wins, q_n is always ~q.
// ----------------------------------------------------------------------------
module ttl_dff_bank
    import ttl_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 0,
    parameter bit RESET_VALUE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    ttl_dff_bank_if.slave     bus
);

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            logic             w_edge;
            ttl_action_e      w_act;
            logic [WIDTH-1:0] r_q;
            logic             r_rise;

            ttl_edge_det #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_edge (
                .clk    (clk),
                .rst    (rst),
                .i_tclk (bus.tclk[c]),
                .o_edge (w_edge)
            );

            // Decide this channel's action from its own pins only, so
            // channels can never influence each other.
            always_comb begin
                w_act = decode_action(bus.clr_n[c], bus.pre_n[c], w_edge);
            end

            // Flop contents and capture strobe. rise is only ever high for the
            // single cycle in which newly captured data appears on q.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q    <= {WIDTH{RESET_VALUE}};
                    r_rise <= 1'b0;
                end else begin
                    r_rise <= 1'b0;
                    unique case (w_act)
                        CLEAR:   r_q <= '0;
                        PRESET:  r_q <= '1;
                        CAPTURE: begin
                            r_q    <= bus.d[c*WIDTH +: WIDTH];
                            r_rise <= 1'b1;
                        end
                        default: r_q <= r_q;
                    endcase
                end
            end

`ifdef TTL_DFF_BOTH_LOW_EN
            logic r_both;

            // Remembers that both clear and preset were low on the last edge;
            // while set, q_n is forced high alongside q, mimicking the part.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_both <= 1'b0;
                end else begin
                    r_both <= ~bus.clr_n[c] & ~bus.pre_n[c];
                end
            end

            assign bus.q_n[c*WIDTH +: WIDTH] = r_both ? {WIDTH{1'b1}} : ~r_q;
`else
            assign bus.q_n[c*WIDTH +: WIDTH] = ~r_q;
`endif

            assign bus.q[c*WIDTH +: WIDTH] = r_q;
            assign bus.rise[c]             = r_rise;
        end
    endgenerate

endmodule

// File: tb/tb_ttl_dff_bank.sv
// ----------------------------------------------------------------------------
// Testbench : tb_ttl_dff_bank
// Purpose   : Directed checks of ttl_dff_bank. dut0 is CHANNELS=2 WIDTH=4
//             with no synchroniser and RESET_VALUE=0; dut2 is the same shape
//             with two synchroniser stages and RESET_VALUE=1.
// Macro     : TTL_DFF_BOTH_LOW_EN selects the expected values of the
//             clear-and-preset-both-low steps.
// ----------------------------------------------------------------------------
module tb_ttl_dff_bank;

    logic clk;
    logic rst0;
    logic rst2;

    int nCompared;
    int nMismatched;

`ifdef TTL_DFF_BOTH_LOW_EN
    localparam logic [7:0] BOTH_Q      = 8'hFF;
    localparam logic [7:0] BOTH_REL_Q  = 8'hFF;
    localparam logic [7:0] BOTH_REL_QN = 8'h00;
`else
    localparam logic [7:0] BOTH_Q      = 8'hF0;
    localparam logic [7:0] BOTH_REL_Q  = 8'hF0;
    localparam logic [7:0] BOTH_REL_QN = 8'h0F;
`endif

    ttl_dff_bank_if #(.CHANNELS(2), .WIDTH(4)) if0 ();
    ttl_dff_bank_if #(.CHANNELS(2), .WIDTH(4)) if2 ();

    ttl_dff_bank #(
        .CHANNELS    (2),
        .WIDTH       (4),
        .SYNC_STAGES (0),
        .RESET_VALUE (1'b0)
    ) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (if0)
    );

    ttl_dff_bank #(
        .CHANNELS    (2),
        .WIDTH       (4),
        .SYNC_STAGES (2),
        .RESET_VALUE (1'b1)
    ) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (if2)
    );

    // Free-running system clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One system clock; outputs are looked at 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset with tclk high, release, then hold five clocks: nothing captures.
    task automatic test_reset();
        rst0 = 1'b1;
        rst2 = 1'b1;
        if0.tclk = 2'b11; if0.clr_n = 2'b11; if0.pre_n = 2'b11; if0.d = 8'h00;
        if2.tclk = 2'b11; if2.clr_n = 2'b11; if2.pre_n = 2'b11; if2.d = 8'h00;
        tick();
        tick();
        nCompared++;
        if (if0.q !== 8'h00) begin
            nMismatched++;
            $display("[TB] FAIL reset_q0: got %h expected %h", if0.q, 8'h00);
        end
        nCompared++;
        if (if2.q !== 8'hFF) begin
            nMismatched++;
            $display("[TB] FAIL reset_q2: got %h expected %h", if2.q, 8'hFF);
        end
        rst0 = 1'b0;
        rst2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            nCompared++;
            if (if0.q !== 8'h00 || if0.q_n !== 8'hFF || if0.rise !== 2'b00) begin
                nMismatched++;
                $display("[TB] FAIL hold_after_reset0 cyc%0d: got q=%h qn=%h rise=%b expected q=00 qn=ff rise=00",
                         i, if0.q, if0.q_n, if0.rise);
            end
            nCompared++;
            if (if2.q !== 8'hFF || if2.rise !== 2'b00) begin
                nMismatched++;
                $display("[TB] FAIL hold_after_reset2 cyc%0d: got q=%h rise=%b expected q=ff rise=00",
                         i, if2.q, if2.rise);
            end
        end
    endtask

    // ch0 captures 0xA on a tclk rise; ch1 stays put; rise is one cycle wide.
    task automatic test_capture();
        if0.tclk[0] = 1'b0;
        if0.d       = 8'h5A;
        tick();
        nCompared++;
        if (if0.q !== 8'h00 || if0.rise !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL capture_low: got q=%h rise=%b expected q=00 rise=00", if0.q, if0.rise);
        end
        if0.tclk[0] = 1'b1;
        tick();
        nCompared++;
        if (if0.q !== 8'h0A || if0.rise !== 2'b01) begin
            nMismatched++;
            $display("[TB] FAIL capture_q: got q=%h rise=%b expected q=0a rise=01", if0.q, if0.rise);
        end
        tick();
        nCompared++;
        if (if0.q !== 8'h0A || if0.rise !== 2'b00 || if0.q_n !== 8'hF5) begin
            nMismatched++;
            $display("[TB] FAIL capture_after: got q=%h qn=%h rise=%b expected q=0a qn=f5 rise=00",
                     if0.q, if0.q_n, if0.rise);
        end
    endtask

    // ch1 cleared while its tclk rises twice; edges are lost until after release.
    task automatic test_clear();
        logic [3:0] tclkSeq;
        tclkSeq = 4'b1010;
        // Preload ch1 with 0x3 so the clear is visible.
        if0.d       = 8'h3A;
        if0.tclk[1] = 1'b0;
        tick();
        if0.tclk[1] = 1'b1;
        tick();
        nCompared++;
        if (if0.q !== 8'h3A || if0.rise !== 2'b10) begin
            nMismatched++;
            $display("[TB] FAIL preload_ch1: got q=%h rise=%b expected q=3a rise=10", if0.q, if0.rise);
        end
        if0.clr_n[1] = 1'b0;
        if0.d        = 8'hFA;
        for (int i = 0; i < 4; i++) begin
            if0.tclk[1] = tclkSeq[i];
            tick();
            nCompared++;
            if (if0.q !== 8'h0A || if0.rise !== 2'b00) begin
                nMismatched++;
                $display("[TB] FAIL clear_active cyc%0d: got q=%h rise=%b expected q=0a rise=00",
                         i, if0.q, if0.rise);
            end
        end
        // Release with tclk already high: no capture.
        if0.clr_n[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            nCompared++;
            if (if0.q !== 8'h0A || if0.rise !== 2'b00) begin
                nMismatched++;
                $display("[TB] FAIL clear_release cyc%0d: got q=%h rise=%b expected q=0a rise=00",
                         i, if0.q, if0.rise);
            end
        end
        if0.tclk[1] = 1'b0;
        tick();
        if0.tclk[1] = 1'b1;
        tick();
        nCompared++;
        if (if0.q !== 8'hFA || if0.rise !== 2'b10) begin
            nMismatched++;
            $display("[TB] FAIL clear_next_rise: got q=%h rise=%b expected q=fa rise=10", if0.q, if0.rise);
        end
    endtask

    // Clear and preset combinations on ch0 with tclk held high.
    task automatic test_both_low();
        logic [1:0] clrSeq [7];
        logic [1:0] preSeq [7];
        logic [7:0] expQ   [7];
        logic [7:0] expQn  [7];
        // {clr_n, pre_n} per step for ch0; ch1 pins stay high.
        clrSeq = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b11};
        preSeq = '{2'b10, 2'b11, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11};
        expQ   = '{BOTH_Q, 8'hF0, 8'hF0, 8'hFF, 8'hFF, BOTH_Q, BOTH_REL_Q};
        expQn  = '{8'h0F,  8'h0F, 8'h0F, 8'h00, 8'h00, 8'h0F, BOTH_REL_QN};
        for (int i = 0; i < 7; i++) begin
            if0.clr_n = clrSeq[i];
            if0.pre_n = preSeq[i];
            tick();
            nCompared++;
            if (if0.q !== expQ[i] || if0.q_n !== expQn[i] || if0.rise !== 2'b00) begin
                nMismatched++;
                $display("[TB] FAIL clr_pre step%0d: got q=%h qn=%h rise=%b expected q=%h qn=%h rise=00",
                         i, if0.q, if0.q_n, if0.rise, expQ[i], expQn[i]);
            end
        end
    endtask

    // ch0 tclk toggles every clock; each rise captures the current d.
    task automatic test_back_to_back();
        logic [3:0] vals [4];
        logic [3:0] prevQ;
        vals  = '{4'h1, 4'h8, 4'h6, 4'hE};
        prevQ = BOTH_REL_Q[3:0];
        for (int i = 0; i < 4; i++) begin
            if0.tclk[0] = 1'b0;
            if0.d       = {4'h0, vals[i]};
            tick();
            nCompared++;
            if (if0.q !== {4'hF, prevQ} || if0.rise !== 2'b00) begin
                nMismatched++;
                $display("[TB] FAIL b2b_low%0d: got q=%h rise=%b expected q=%h rise=00",
                         i, if0.q, if0.rise, {4'hF, prevQ});
            end
            if0.tclk[0] = 1'b1;
            tick();
            nCompared++;
            if (if0.q !== {4'hF, vals[i]} || if0.rise !== 2'b01) begin
                nMismatched++;
                $display("[TB] FAIL b2b_high%0d: got q=%h rise=%b expected q=%h rise=01",
                         i, if0.q, if0.rise, {4'hF, vals[i]});
            end
            prevQ = vals[i];
        end
    endtask

    // Same-cycle events on both channels: capture on ch0 with clear on ch1,
    // then a simultaneous capture on both.
    task automatic test_independent();
        if0.tclk = 2'b00;
        tick();
        if0.d     = 8'h69;
        if0.tclk  = 2'b11;
        if0.clr_n = 2'b01;
        tick();
        nCompared++;
        if (if0.q !== 8'h09 || if0.q_n !== 8'hF6 || if0.rise !== 2'b01) begin
            nMismatched++;
            $display("[TB] FAIL indep_cap_clr: got q=%h qn=%h rise=%b expected q=09 qn=f6 rise=01",
                     if0.q, if0.q_n, if0.rise);
        end
        if0.clr_n = 2'b11;
        if0.tclk  = 2'b00;
        tick();
        if0.d    = 8'h3C;
        if0.tclk = 2'b11;
        tick();
        nCompared++;
        if (if0.q !== 8'h3C || if0.rise !== 2'b11) begin
            nMismatched++;
            $display("[TB] FAIL indep_both_cap: got q=%h rise=%b expected q=3c rise=11", if0.q, if0.rise);
        end
    endtask

    // Two synchroniser stages: capture lands on the third clock after tclk
    // goes high, and a long high level gives a single rise pulse.
    task automatic test_sync_latency();
        int riseCount;
        riseCount   = 0;
        if2.tclk[0] = 1'b0;
        if2.d       = 8'h05;
        for (int i = 0; i < 3; i++) tick();
        if2.tclk[0] = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            tick();
            if (if2.rise[0] === 1'b1) riseCount++;
            if (i == 2) begin
                nCompared++;
                if (if2.q !== 8'hFF) begin
                    nMismatched++;
                    $display("[TB] FAIL sync_early: got q=%h expected ff", if2.q);
                end
            end
            if (i == 3) begin
                nCompared++;
                if (if2.q !== 8'hF5 || if2.rise !== 2'b01) begin
                    nMismatched++;
                    $display("[TB] FAIL sync_capture: got q=%h rise=%b expected q=f5 rise=01", if2.q, if2.rise);
                end
            end
        end
        nCompared++;
        if (riseCount !== 1) begin
            nMismatched++;
            $display("[TB] FAIL sync_single_rise: got %0d pulses expected 1", riseCount);
        end
    endtask

    // Reset while an edge is inside the synchroniser: it must be discarded.
    task automatic test_reset_midstream();
        if2.tclk[0] = 1'b0;
        if2.d       = 8'h0C;
        for (int i = 0; i < 3; i++) tick();
        if2.tclk[0] = 1'b1;
        tick();
        rst2 = 1'b1;
        #1;
        nCompared++;
        if (if2.q !== 8'hFF || if2.rise !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL midreset_async: got q=%h rise=%b expected q=ff rise=00", if2.q, if2.rise);
        end
        tick();
        rst2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            nCompared++;
            if (if2.q !== 8'hFF || if2.rise !== 2'b00) begin
                nMismatched++;
                $display("[TB] FAIL midreset_after cyc%0d: got q=%h rise=%b expected q=ff rise=00",
                         i, if2.q, if2.rise);
            end
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        test_reset();
        test_capture();
        test_clear();
        test_both_low();
        test_back_to_back();
        test_independent();
        test_sync_latency();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
